// File: rtl/sram_pkg.sv
// Shared definitions for the instruction-SRAM access path: default widths,
// requester ids and the read-return tag.
package sram_pkg;
  localparam int ADDR_WIDTH_DEF = 18;
  localparam int DATA_WIDTH_DEF = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LD = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_pend_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a bounded lock that lets m1 burst.
module rr_arb2
  import sram_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       clka,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock1,
  output logic [1:0] gnt
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic          last_q, last_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic          hold;

  always_comb begin
    hold = locked_q && (lock_cnt_q < CW'(MAX_LOCK));
    gnt  = 2'b00;
    if (!rst) begin
      if (req0 && req1) begin
        if (hold || (last_q == REQ_IF)) gnt = 2'b10;
        else                            gnt = 2'b01;
      end else if (req0) begin
        gnt = 2'b01;
      end else if (req1) begin
        gnt = 2'b10;
      end
    end

    last_d = last_q;
    if (gnt[0])      last_d = REQ_IF;
    else if (gnt[1]) last_d = REQ_LD;

    // The count only measures how long m0 has been kept waiting; it saturates.
    lock_cnt_d = lock_cnt_q;
    if (gnt[0] || !req0)
      lock_cnt_d = '0;
    else if (gnt[1] && (lock_cnt_q < CW'(MAX_LOCK)))
      lock_cnt_d = lock_cnt_q + CW'(1);

    locked_d = gnt[1] && lock1;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      last_q     <= REQ_LD;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end
endmodule

// File: rtl/inst_ram_arbiter.sv
// Shares the single-port instruction SRAM between fetch (m0) and loader (m1):
// request mux towards the SRAM and read-data return tagging.
module inst_ram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_LOCK   = 8
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic [DATA_WIDTH/8-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic                    m1_req,
  input  logic [DATA_WIDTH/8-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic                    m1_lock,
  output logic                    m0_gnt,
  output logic                    m1_gnt,
  output logic                    m0_rvalid,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  rd_pend_t              rd_pend_q, rd_pend_d;

  rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clka  (clka),
    .rst   (rst),
    .req0  (m0_req),
    .req1  (m1_req),
    .lock1 (m1_lock),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    ram_we  = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (gnt[0]) begin
      ram_we  = m0_we;
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
    end else if (gnt[1]) begin
      ram_we  = m1_we;
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
    end
    rd_pend_d.valid = (|gnt) && (ram_we == '0);
    rd_pend_d.id    = gnt[1] ? REQ_LD : REQ_IF;
  end

  // Idle cycles replay the last address/data so the SRAM pins never go X.
  assign ram_en    = |gnt;
  assign ram_addr  = addr_d;
  assign ram_wdata = wdata_d;

  always_ff @(posedge clka) begin
    if (rst) begin
      rd_pend_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Reset also swallows a return already in flight.
  assign m0_rvalid = rd_pend_q.valid && (rd_pend_q.id == REQ_IF) && !rst;
  assign m1_rvalid = rd_pend_q.valid && (rd_pend_q.id == REQ_LD) && !rst;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;
endmodule
